cnt_burst_sequencer: RTL and testbench
======================================

Name: cnt_burst_sequencer

Overview:
- Owns an 8-bit up/down counter register and shares it between NREQ requesters.
- Each requester asks for a burst of N unit steps in one direction (up or down).
- The block arbitrates round-robin, then sequences the burst as one up or down pulse per cycle into the counter.
- Bursts are clamped at the counter limits so the count never wraps.
- It sits between client logic and the counter datapath; up/down are exported so counter properties can be checked directly.

Parameters:
- NREQ, 4: number of requesters.
- WIDTH, 8: counter width.
- LENW, 4: width of each requester's burst-length field.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request; held high until the matching done pulse
- dir  input  NREQ  per-requester direction, 1=up, 0=down; sampled only at grant
- len  input  NREQ*LENW  per-requester burst length, requester i in bits [i*LENW +: LENW]; sampled only at grant
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle completion pulse to the granted requester
- sat  output  1  one-cycle pulse with done when the burst was clamped
- busy  output  1  high in RUN and DONE
- up  output  1  counter increment strobe
- down  output  1  counter decrement strobe
- cnt  output  WIDTH  counter value

Behaviour:
- Reset is synchronous and active-high; clock is clk. On reset:
  - state=IDLE; gnt, done, sat all 0; cnt=0.
  - RR pointer=0, so requester 0 has highest priority.
  - Reset mid-burst aborts the burst; no done is issued.
- Counter register:
  - if reset, cnt<=0
  - else if up, cnt<=cnt+1
  - else if down, cnt<=cnt-1
- up and down are combinational: up = (state==RUN)&&dir_q; down = (state==RUN)&&!dir_q. They are never both high.
- State IDLE:
  - If any req is high, pick the first requester at or after the RR pointer, wrapping.
  - Latch its dir into dir_q and its len.
  - Compute headroom: for up, 2^WIDTH-1-cnt; for down, cnt.
  - eff = min(len, headroom); sat_q = (len > headroom).
  - Set gnt one-hot.
  - If eff==0, go to DONE; else remaining<=eff and go to RUN.
- State RUN:
  - One strobe per cycle; remaining decrements each cycle.
  - When remaining==1, go to DONE.
- State DONE (one cycle):
  - done[g]=1 and sat=sat_q.
  - gnt clears at the end of the cycle.
  - RR pointer <= g+1 mod NREQ.
  - Return to IDLE.
- Timing: req high in IDLE at cycle t gives:
  - gnt at t+1;
  - strobes during t+1..t+eff;
  - cnt reaches final value at t+eff+1;
  - done during t+eff+1;
  - earliest next grant at t+eff+3 (IDLE cycle at t+eff+2 does the arbitration).
- Fairness: a requester holding req after done is not served ahead of other pending requesters.
- dir, len and req changes of non-granted requesters during RUN are ignored.
- Dropping req of the granted requester mid-burst is ignored; the burst completes.
- Invariants:
  - Per completed burst, |cnt_end - cnt_start| == eff.
  - cnt never wraps.
  - gnt is one-hot or zero.

Test Plan:
- Reset, then req[0]=1, dir=up, len=3 -> gnt=0001 the next cycle; up high 3 cycles; cnt 0→3; done[0] pulse; sat=0.
- cnt=3, req[1] down len=5 -> down high 3 cycles; cnt=0; done[1] with sat=1.
- cnt=0, req[2] down len=2 -> zero strobes; IDLE→DONE; done[2] and sat=1 in the second cycle; cnt stays 0.
- All four req held high, each up len=1 -> grant order 0,1,2,3,0; each done followed by a grant to the next index; cnt increments by 1 per burst.
- cnt=250, req[3] up len=15 -> 5 up pulses; cnt=255; sat=1; no wrap to 0.
- Mid-burst (up, len=8, after 4 strobes) assert reset -> next cycle cnt=0, gnt=0, IDLE, no done; RR pointer reset to 0.

Source files
------------

// File: rtl/cnt_burst_sequencer.sv
// Round-robin burst sequencer that shares one saturating up/down counter between NREQ requesters.
// Each granted burst is clamped to the counter headroom and issued as one strobe per cycle.
module cnt_burst_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      dir,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 sat,
    output logic                 busy,
    output logic                 up,
    output logic                 down,
    output logic [WIDTH-1:0]     cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = WIDTH + LENW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   sel_idx;
    logic            found;
    logic            dir_q;
    logic            sat_q;
    logic [LENW-1:0] remaining;
    logic [LENW-1:0] len_sel;
    logic [LENW-1:0] eff;
    logic [WIDTH-1:0] headroom;
    logic            sat_n;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) sum = sum - NREQ;
        return IW'(sum);
    endfunction

    // Search starts at the RR pointer so the last-served requester drops to lowest priority.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[wrap_idx(rr_ptr, i)]) begin
                found   = 1'b1;
                sel_idx = wrap_idx(rr_ptr, i);
            end
        end
    end

    // Clamp the requested length to the distance left before the counter would wrap.
    always_comb begin
        len_sel  = len[sel_idx*LENW +: LENW];
        headroom = dir[sel_idx] ? ({WIDTH{1'b1}} - cnt) : cnt;
        sat_n    = CW'(len_sel) > CW'(headroom);
        eff      = sat_n ? LENW'(headroom) : len_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (found) state_n = (eff == '0) ? DONE : RUN;
            end
            RUN: begin
                if (remaining == LENW'(1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            dir_q     <= 1'b0;
            sat_q     <= 1'b0;
            remaining <= '0;
            cnt       <= '0;
        end else begin
            if (up)        cnt <= cnt + 1'b1;
            else if (down) cnt <= cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= NREQ'(1) << sel_idx;
                        gnt_idx   <= sel_idx;
                        dir_q     <= dir[sel_idx];
                        sat_q     <= sat_n;
                        remaining <= eff;
                    end
                end
                RUN: begin
                    remaining <= remaining - 1'b1;
                end
                DONE: begin
                    gnt    <= '0;
                    rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        up   = (state == RUN) && dir_q;
        down = (state == RUN) && !dir_q;
        done = (state == DONE) ? gnt : '0;
        sat  = (state == DONE) && sat_q;
        busy = (state != IDLE);
    end

    // Structural invariants: single grant, exclusive strobes, no wrap at either limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(gnt));
            assert (!(up && down));
            assert (!(up && (cnt == {WIDTH{1'b1}})));
            assert (!(down && (cnt == '0)));
        end
    end

endmodule

// File: tb/tb_cnt_burst_sequencer.sv
// Directed testbench for cnt_burst_sequencer with hand-computed expectations per scenario.
module tb_cnt_burst_sequencer;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LENW  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      dir;
    logic [NREQ*LENW-1:0] len;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 sat;
    logic                 busy;
    logic                 up;
    logic                 down;
    logic [WIDTH-1:0]     cnt;

    int checks   = 0;
    int failures = 0;

    cnt_burst_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dir   (dir),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .sat   (sat),
        .busy  (busy),
        .up    (up),
        .down  (down),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts strobes until done appears; gives up after a fixed cycle budget.
    task automatic wait_done(output int n_up, output int n_down, output bit ok);
        n_up   = 0;
        n_down = 0;
        ok     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
            if (up)   n_up++;
            if (down) n_down++;
            tick();
        end
    endtask

    task automatic do_burst(input int idx, input bit d, input int l, output bit ok);
        int nu, nd;
        req = '0;
        req[idx] = 1'b1;
        dir[idx] = d;
        len[idx*LENW +: LENW] = LENW'(l);
        tick();
        wait_done(nu, nd, ok);
        req = '0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; dir = '0; len = '0;
        tick();
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done got=%b exp=%b", done, 4'b0000); end
        checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat got=%b exp=0", sat); end
        checks++; if (cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        tick();
        checks++; if ({busy, up, down} !== 3'b000) begin failures++; $display("[TB] FAIL reset_idle got=%b exp=000", {busy, up, down}); end
    endtask

    task automatic test_basic_up();
        int nu, nd; bit ok;
        req = 4'b0001; dir[0] = 1'b1; len[3:0] = 4'd3;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL up3_gnt got=%b exp=0001", gnt); end
        checks++; if (up !== 1'b1) begin failures++; $display("[TB] FAIL up3_first_strobe got=%b exp=1", up); end
        wait_done(nu, nd, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL up3_timeout got=no_done exp=done"); end
        checks++; if (nu != 3 || nd != 0) begin failures++; $display("[TB] FAIL up3_strobes got=up%0d/down%0d exp=up3/down0", nu, nd); end
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL up3_done got=%b exp=0001", done); end
        checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL up3_sat got=%b exp=0", sat); end
        checks++; if (cnt !== 8'd3) begin failures++; $display("[TB] FAIL up3_cnt got=%0d exp=3", cnt); end
        req = '0;
        tick();
        checks++; if ({gnt, done} !== 8'h00) begin failures++; $display("[TB] FAIL up3_clear got=%b exp=00000000", {gnt, done}); end
    endtask

    task automatic test_down_sat();
        int nu, nd; bit ok;
        req = 4'b0010; dir[1] = 1'b0; len[7:4] = 4'd5;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL dnsat_gnt got=%b exp=0010", gnt); end
        wait_done(nu, nd, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL dnsat_timeout got=no_done exp=done"); end
        checks++; if (nd != 3 || nu != 0) begin failures++; $display("[TB] FAIL dnsat_strobes got=up%0d/down%0d exp=up0/down3", nu, nd); end
        checks++; if (done !== 4'b0010 || sat !== 1'b1) begin failures++; $display("[TB] FAIL dnsat_done got=%b/%b exp=0010/1", done, sat); end
        checks++; if (cnt !== 8'd0) begin failures++; $display("[TB] FAIL dnsat_cnt got=%0d exp=0", cnt); end
        req = '0;
        tick();
    endtask

    task automatic test_zero_len();
        req = 4'b0100; dir[2] = 1'b0; len[11:8] = 4'd2;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL zero_gnt got=%b exp=0100", gnt); end
        checks++; if (done !== 4'b0100 || sat !== 1'b1) begin failures++; $display("[TB] FAIL zero_done got=%b/%b exp=0100/1", done, sat); end
        checks++; if ({up, down} !== 2'b00) begin failures++; $display("[TB] FAIL zero_strobes got=%b exp=00", {up, down}); end
        req = '0;
        tick();
        checks++; if (cnt !== 8'd0 || done !== 4'b0000) begin failures++; $display("[TB] FAIL zero_after got=cnt%0d/%b exp=cnt0/0000", cnt, done); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111; dir = 4'b1111; len = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            checks++; if (gnt !== exp_g || up !== 1'b1) begin failures++; $display("[TB] FAIL rr_gnt%0d got=%b/%b exp=%b/1", k, gnt, up, exp_g); end
            tick();
            checks++; if (done !== exp_g || cnt !== 8'(k + 1)) begin failures++; $display("[TB] FAIL rr_done%0d got=%b/cnt%0d exp=%b/cnt%0d", k, done, cnt, exp_g, k + 1); end
            if (k == 4) req = '0;
            tick();
            checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle%0d got=%b/%b exp=0000/0", k, gnt, busy); end
        end
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL rr_quiet got=%b exp=0000", gnt); end
    endtask

    task automatic test_upper_sat();
        int nu, nd, tmo; bit ok;
        tmo = 0;
        for (int b = 0; b < 16; b++) begin
            do_burst(0, 1'b1, 15, ok);
            if (!ok) tmo++;
        end
        do_burst(0, 1'b1, 5, ok);
        if (!ok) tmo++;
        checks++; if (tmo != 0) begin failures++; $display("[TB] FAIL fill_timeouts got=%0d exp=0", tmo); end
        checks++; if (cnt !== 8'd250) begin failures++; $display("[TB] FAIL fill_cnt got=%0d exp=250", cnt); end
        req = 4'b1000; dir[3] = 1'b1; len[15:12] = 4'd15;
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL upsat_gnt got=%b exp=1000", gnt); end
        wait_done(nu, nd, ok);
        checks++; if (!ok || nu != 5 || nd != 0) begin failures++; $display("[TB] FAIL upsat_strobes got=ok%0d/up%0d/down%0d exp=ok1/up5/down0", ok, nu, nd); end
        checks++; if (done !== 4'b1000 || sat !== 1'b1) begin failures++; $display("[TB] FAIL upsat_done got=%b/%b exp=1000/1", done, sat); end
        checks++; if (cnt !== 8'd255) begin failures++; $display("[TB] FAIL upsat_cnt got=%0d exp=255", cnt); end
        req = '0;
        tick();
        tick();
        checks++; if (cnt !== 8'd255) begin failures++; $display("[TB] FAIL upsat_nowrap got=%0d exp=255", cnt); end
    endtask

    task automatic test_ignore_changes();
        int nu, nd; bit ok;
        req = 4'b0010; dir[1] = 1'b0; len[7:4] = 4'd4;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL ign_gnt got=%b exp=0010", gnt); end
        req = 4'b0100; dir = 4'b1111; len = 16'hFFFF;
        wait_done(nu, nd, ok);
        checks++; if (!ok || nd != 4 || nu != 0) begin failures++; $display("[TB] FAIL ign_strobes got=ok%0d/up%0d/down%0d exp=ok1/up0/down4", ok, nu, nd); end
        checks++; if (done !== 4'b0010 || sat !== 1'b0) begin failures++; $display("[TB] FAIL ign_done got=%b/%b exp=0010/0", done, sat); end
        checks++; if (cnt !== 8'd251) begin failures++; $display("[TB] FAIL ign_cnt got=%0d exp=251", cnt); end
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL ign_idle got=%b exp=0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL ign_next_gnt got=%b exp=0100", gnt); end
        wait_done(nu, nd, ok);
        checks++; if (!ok || nu != 4 || sat !== 1'b1 || cnt !== 8'd255) begin failures++; $display("[TB] FAIL ign_next_burst got=ok%0d/up%0d/sat%b/cnt%0d exp=ok1/up4/sat1/cnt255", ok, nu, sat, cnt); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int nu, nd; bit ok;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_burst(2, 1'b1, 2, ok);
        checks++; if (!ok || cnt !== 8'd2) begin failures++; $display("[TB] FAIL mid_pre got=ok%0d/cnt%0d exp=ok1/cnt2", ok, cnt); end
        req = 4'b0100; dir[2] = 1'b1; len[11:8] = 4'd8;
        tick();
        for (int s = 0; s < 4; s++) tick();
        checks++; if (cnt !== 8'd6 || up !== 1'b1) begin failures++; $display("[TB] FAIL mid_progress got=cnt%0d/up%b exp=cnt6/up1", cnt, up); end
        reset = 1'b1;
        tick();
        checks++; if (cnt !== 8'd0 || gnt !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset got=cnt%0d/%b exp=cnt0/0000", cnt, gnt); end
        checks++; if (done !== 4'b0000 || busy !== 1'b0 || up !== 1'b0) begin failures++; $display("[TB] FAIL mid_abort got=%b/%b/%b exp=0000/0/0", done, busy, up); end
        reset = 1'b0;
        req = 4'b1010; dir = 4'b1111; len = 16'h1111;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_rrptr got=%b exp=0010", gnt); end
        wait_done(nu, nd, ok);
        checks++; if (!ok || done !== 4'b0010 || cnt !== 8'd1) begin failures++; $display("[TB] FAIL mid_after got=ok%0d/%b/cnt%0d exp=ok1/0010/cnt1", ok, done, cnt); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_up();
        test_down_sat();
        test_zero_len();
        test_round_robin();
        test_upper_sat();
        test_ignore_changes();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
